station_network_aggregator: RTL and testbench
=============================================

// Module: station_network_aggregator
// PURPOSE
//  Upstream of each dropoff station: collects per-station percentage_stored (S) reports,
//  one table entry per station, and periodically publishes network-wide totals.
//  total_percentage_stored (R) and number_of_stations (G) feed every dropoff station's
//  trains-limit logic. Stale stations age out so that G tracks live stations only.
// PARAMETERS
//  INT            31    MSB index of data words (data width INT+1)
//  MAX_STATIONS   16    table entries; station ids 0..MAX_STATIONS-1
//  ID_W           4     width of station id, >= clog2(MAX_STATIONS)
//  SAMPLE_PERIOD  1024  IDLE cycles between snapshots (>= 2)
//  STALE_PERIODS  4     snapshots without a report before an entry expires (>= 1)
// PORTS
//  clk                      in   1      clock; all state updates on rising edge
//  rst_n                    in   1      async active-low reset
//  precision                in   INT+1  P; full-scale value of a percentage report
//  report_valid             in   1      report offered this cycle
//  report_ready             out  1      aggregator accepts reports (high only in IDLE)
//  report_station_id        in   ID_W   reporting station
//  report_percentage        in   INT+1  station's S value
//  report_leave             in   1      1 = deregister station; percentage ignored
//  total_percentage_stored  out  INT+1  R; sum of S over live entries
//  number_of_stations       out  INT+1  G; live entry count, never 0
//  snapshot_valid           out  1      1-cycle pulse when R/G update
// BEHAVIOUR
//  Reset (async assert, sync deassert): all entries invalid, ages 0; R=0, G=1,
//   snapshot_valid=0, report_ready=0, FSM=IDLE, period counter 0. report_ready rises
//   on the first clock edge after rst_n deasserts.
//  Table entry: live bit, value [INT:0], age [clog2(STALE_PERIODS+1)-1:0].
//  Handshake: transfer when report_valid && report_ready on a rising edge. Senders hold
//   id/percentage/leave stable while valid && !ready. Accepted report:
//   - leave=0: live=1, value=min(report_percentage, precision), age=0.
//   - leave=1: live=0, value=0.
//   - id >= MAX_STATIONS: accepted (ready unchanged), discarded, no state change.
//   - several reports for same id in one period: last one wins.
//  FSM:
//   IDLE    report_ready=1; period counter increments every cycle; on the cycle
//           counter==SAMPLE_PERIOD-1, an offered report is still accepted, counter
//           clears, next state SCAN.
//   SCAN    report_ready=0; index 0..MAX_STATIONS-1, one entry per cycle. Live entry:
//           sum += value (saturate at 2^(INT+1)-1), count += 1, age += 1; if the
//           incremented age == STALE_PERIODS, entry goes non-live for later periods
//           (its value still counts in this snapshot). After last index -> PUBLISH.
//   PUBLISH report_ready=0; R<=sum; G<=(count==0 ? 1 : count); snapshot_valid=1;
//           clear sum/count; next IDLE.
//  Latency: snapshot period = SAMPLE_PERIOD + MAX_STATIONS + 1 cycles. A report
//   accepted in IDLE is visible in R at the next PUBLISH.
//  R/G hold between PUBLISH cycles; downstream may sample them any time.
//  G is never 0 because downstream divides R by G; with no live stations R=0, G=1.
//  precision change takes effect on subsequent accepts only; stored values not rescaled.
//  Reset mid-SCAN: partial sum discarded, outputs return to reset values at once.
// TESTING
//  1. Reset, no reports, run 2 periods -> snapshot_valid pulses each period; R=0, G=1.
//  2. P=1000; ids 0,1,2 report 200,400,900 -> next snapshot R=1500, G=3.
//  3. id 5 reports 1200 with P=1000 -> stored 1000; id 5 then leave=1 -> next R drops
//     by 1000, G drops by 1.
//  4. STALE_PERIODS=4; id 3 reports 500 once -> counted in snapshots 1..4, absent from 5.
//  5. report_valid held across IDLE->SCAN boundary -> ready=0 for MAX_STATIONS+1 cycles,
//     report accepted on first IDLE cycle, counted in following snapshot.
//  6. INT=7, three stations report 200 with P=255 -> R saturates at 255, G=3; assert
//     rst_n low mid-SCAN -> R=0, G=1, report_ready=0 immediately.

Source files
------------

// File: rtl/station_network_aggregator.sv
// Collects per-station percentage reports into a table and periodically publishes
// the network-wide sum (R) and live station count (G) for downstream limit logic.
//
// state   | meaning
// IDLE    | accepting reports, counting the sample period
// SCAN    | walking the table one entry per cycle, accumulating and aging
// PUBLISH | driving R/G from the accumulators, then back to IDLE
module station_network_aggregator #(
    parameter int INT           = 31,
    parameter int MAX_STATIONS  = 16,
    parameter int ID_W          = 4,
    parameter int SAMPLE_PERIOD = 1024,
    parameter int STALE_PERIODS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [INT:0]    precision,
    input  logic            report_valid,
    output logic            report_ready,
    input  logic [ID_W-1:0] report_station_id,
    input  logic [INT:0]    report_percentage,
    input  logic            report_leave,
    output logic [INT:0]    total_percentage_stored,
    output logic [INT:0]    number_of_stations,
    output logic            snapshot_valid
);
    localparam int W     = INT + 1;
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int IDX_W = (MAX_STATIONS > 1) ? $clog2(MAX_STATIONS) : 1;
    localparam int AGE_W = $clog2(STALE_PERIODS + 1);
    localparam int NUM_W = $clog2(MAX_STATIONS + 1);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_STATIONS - 1);
    localparam logic [AGE_W-1:0] STALE_AGE = AGE_W'(STALE_PERIODS);

    typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] period_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [W-1:0]     sum_acc;
    logic [NUM_W-1:0] live_cnt;

    logic             live  [MAX_STATIONS];
    logic [W-1:0]     value [MAX_STATIONS];
    logic [AGE_W-1:0] age   [MAX_STATIONS];

    logic             accept;
    logic             id_in_range;
    logic [W-1:0]     clamped;
    logic [W:0]       sum_ext;
    logic [W-1:0]     sum_sat;
    logic [AGE_W-1:0] age_inc;

    assign accept      = report_valid && report_ready;
    assign id_in_range = int'(report_station_id) < MAX_STATIONS;
    assign clamped     = (report_percentage > precision) ? precision : report_percentage;
    assign sum_ext     = {1'b0, sum_acc} + {1'b0, value[scan_idx]};
    assign sum_sat     = sum_ext[W] ? {W{1'b1}} : sum_ext[W-1:0];
    assign age_inc     = age[scan_idx] + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (period_cnt == LAST_CNT) state_nxt = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_nxt = PUBLISH;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            report_ready            <= 1'b0;
            period_cnt              <= '0;
            scan_idx                <= '0;
            sum_acc                 <= '0;
            live_cnt                <= '0;
            total_percentage_stored <= '0;
            number_of_stations      <= W'(1);
            snapshot_valid          <= 1'b0;
        end else begin
            state          <= state_nxt;
            report_ready   <= (state_nxt == IDLE);
            snapshot_valid <= (state == PUBLISH);
            case (state)
                IDLE: begin
                    period_cnt <= (period_cnt == LAST_CNT) ? '0 : period_cnt + 1'b1;
                    scan_idx   <= '0;
                end
                SCAN: begin
                    if (live[scan_idx]) begin
                        sum_acc  <= sum_sat;
                        live_cnt <= live_cnt + 1'b1;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                PUBLISH: begin
                    total_percentage_stored <= sum_acc;
                    // downstream divides R by G, so an empty network reports one station
                    number_of_stations      <= (live_cnt == '0) ? W'(1) : W'(live_cnt);
                    sum_acc                 <= '0;
                    live_cnt                <= '0;
                end
                default: ;
            endcase
        end
    end

    // Reports only land in IDLE and aging only in SCAN, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_STATIONS; i++) begin
                live[i]  <= 1'b0;
                value[i] <= '0;
                age[i]   <= '0;
            end
        end else if (accept && id_in_range) begin
            if (report_leave) begin
                live[report_station_id]  <= 1'b0;
                value[report_station_id] <= '0;
            end else begin
                live[report_station_id]  <= 1'b1;
                value[report_station_id] <= clamped;
                age[report_station_id]   <= '0;
            end
        end else if (state == SCAN && live[scan_idx]) begin
            age[scan_idx] <= age_inc;
            if (age_inc == STALE_AGE) live[scan_idx] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_station_network_aggregator.sv
// Bench for station_network_aggregator: a per-period model of station liveness checks
// the main instance every cycle; a narrow instance covers saturation and mid-scan reset.
module tb_station_network_aggregator;
    localparam int SP    = 32;
    localparam int MS    = 16;
    localparam int STALE = 4;
    localparam int L     = SP + MS + 1;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [31:0] precision, report_percentage, total_percentage_stored, number_of_stations;
    logic        report_valid, report_ready, report_leave, snapshot_valid;
    logic [3:0]  report_station_id;

    logic [7:0]  precision_b, pct_b, r_b, g_b;
    logic        valid_b, ready_b, leave_b, sv_b;
    logic [1:0]  id_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    station_network_aggregator #(.INT(31), .MAX_STATIONS(MS), .ID_W(4),
        .SAMPLE_PERIOD(SP), .STALE_PERIODS(STALE)) u_dut (
        .clk(clk), .rst_n(rst_n), .precision(precision),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_station_id(report_station_id), .report_percentage(report_percentage),
        .report_leave(report_leave), .total_percentage_stored(total_percentage_stored),
        .number_of_stations(number_of_stations), .snapshot_valid(snapshot_valid));

    station_network_aggregator #(.INT(7), .MAX_STATIONS(4), .ID_W(2),
        .SAMPLE_PERIOD(8), .STALE_PERIODS(4)) u_dut_b (
        .clk(clk), .rst_n(rst2_n), .precision(precision_b),
        .report_valid(valid_b), .report_ready(ready_b),
        .report_station_id(id_b), .report_percentage(pct_b),
        .report_leave(leave_b), .total_percentage_stored(r_b),
        .number_of_stations(g_b), .snapshot_valid(sv_b));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each station remembers whether it is registered, its clamped value and
    // the period it last reported in; it counts in snapshot k (1-based, published at
    // the end of period k-1) while fewer than STALE snapshots have passed since then.
    int     m_live [MS];
    longint m_val  [MS];
    int     m_per  [MS];
    longint exp_r = 0;
    longint exp_g = 1;
    int     c = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            automatic int q = c % L;
            automatic int k = c / L;
            if (c >= L && q == 0) begin
                exp_r = 0;
                exp_g = 0;
                for (int i = 0; i < MS; i++)
                    if (m_live[i] != 0 && (k - 1) - m_per[i] < STALE) begin
                        exp_r += m_val[i];
                        exp_g++;
                    end
                if (exp_r > 64'hFFFF_FFFF) exp_r = 64'hFFFF_FFFF;
                if (exp_g == 0) exp_g = 1;
            end
            chk("ready", report_ready, (c != 0 && q < SP) ? 1 : 0);
            chk("snapshot_valid", snapshot_valid, (c >= L && q == 0) ? 1 : 0);
            chk("R", total_percentage_stored, exp_r);
            chk("G", number_of_stations, exp_g);
            if (report_valid && c != 0 && q < SP && report_station_id < MS) begin
                if (report_leave) begin
                    m_live[report_station_id] = 0;
                    m_val[report_station_id]  = 0;
                end else begin
                    m_live[report_station_id] = 1;
                    m_val[report_station_id]  = (report_percentage > precision) ?
                                                precision : report_percentage;
                    m_per[report_station_id]  = k;
                end
            end
            c++;
        end
    end

    task automatic send(input int id, input int pct, input bit lv);
        int k = 0;
        @(posedge clk); #1;
        report_station_id = 4'(id);
        report_percentage = 32'(pct);
        report_leave      = lv;
        report_valid      = 1'b1;
        do begin @(negedge clk); k++; end while (!report_ready && k < 100);
        chk("send_ready", report_ready, 1);
        @(posedge clk); #1;
        report_valid = 1'b0;
    endtask

    task automatic wait_snap(input string nm, input longint er, input longint eg);
        int k = 0;
        do begin @(negedge clk); k++; end while (!snapshot_valid && k < 200);
        chk({nm, "_pulse"}, snapshot_valid, 1);
        chk({nm, "_R"}, total_percentage_stored, er);
        chk({nm, "_G"}, number_of_stations, eg);
    endtask

    task automatic send_b(input int id, input int pct);
        int k = 0;
        @(posedge clk); #1;
        id_b = 2'(id); pct_b = 8'(pct); leave_b = 1'b0; valid_b = 1'b1;
        do begin @(negedge clk); k++; end while (!ready_b && k < 50);
        chk("b_send_ready", ready_b, 1);
        @(posedge clk); #1;
        valid_b = 1'b0;
    endtask

    task automatic wait_snap_b(input string nm, input longint er, input longint eg);
        int k = 0;
        do begin @(negedge clk); k++; end while (!sv_b && k < 100);
        chk({nm, "_pulse"}, sv_b, 1);
        chk({nm, "_R"}, r_b, er);
        chk({nm, "_G"}, g_b, eg);
    endtask

    initial begin
        int low, k;
        for (int i = 0; i < MS; i++) begin m_live[i] = 0; m_val[i] = 0; m_per[i] = 0; end
        rst_n = 1'b0; rst2_n = 1'b0;
        precision = 32'd1000; report_valid = 1'b0; report_station_id = '0;
        report_percentage = '0; report_leave = 1'b0;
        precision_b = 8'd255; valid_b = 1'b0; id_b = '0; pct_b = '0; leave_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", report_ready, 0);
        chk("rst_sv", snapshot_valid, 0);
        chk("rst_R", total_percentage_stored, 0);
        chk("rst_G", number_of_stations, 1);
        rst_n = 1'b1;

        wait_snap("snap1", 0, 1);
        wait_snap("snap2", 0, 1);

        send(0, 200, 0); send(1, 400, 0); send(2, 900, 0);
        wait_snap("snap3", 1500, 3);
        send(5, 1200, 0);
        wait_snap("snap4", 2500, 4);
        send(5, 0, 1); send(3, 500, 0);
        wait_snap("snap5", 2000, 4);
        wait_snap("snap6", 2000, 4);
        wait_snap("snap7", 500, 1);
        wait_snap("snap8", 500, 1);
        wait_snap("snap9", 0, 1);

        k = 0;
        do begin @(negedge clk); k++; end while (report_ready && k < 100);
        chk("t5_scan_entry", report_ready, 0);
        @(posedge clk); #1;
        report_station_id = 4'd7; report_percentage = 32'd300; report_leave = 1'b0;
        report_valid = 1'b1;
        low = 1;
        k = 0;
        do begin @(negedge clk); k++; if (!report_ready) low++; end
        while (!report_ready && k < 100);
        chk("t5_ready_low_cycles", low, MS + 1);
        @(posedge clk); #1;
        report_valid = 1'b0;
        wait_snap("snap11", 300, 1);

        rst2_n = 1'b1;
        send_b(0, 200); send_b(1, 200); send_b(2, 200);
        wait_snap_b("b_snap1", 255, 3);
        k = 0;
        do begin @(negedge clk); k++; end while (ready_b && k < 50);
        chk("b_scan_entry", ready_b, 0);
        @(negedge clk);
        chk("b_hold_R", r_b, 255);
        #1;
        rst2_n = 1'b0;
        #1;
        chk("b_rst_R", r_b, 0);
        chk("b_rst_G", g_b, 1);
        chk("b_rst_ready", ready_b, 0);
        chk("b_rst_sv", sv_b, 0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        wait_snap_b("b_snap_after_rst", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
